adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational WIDTH-bit full adder/subtractor between two requesters in the toy processor datapath.
- Accepts a request, latches its operands and opcode, drives the shared adder, registers the sum and carry, and returns a one-cycle done pulse to the granted requester.
- Sits between the instruction-side requesters and the shared adder instance. The adder itself stays external.

Parameters:
- WIDTH, 8, operand/result width; must match the shared adder.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request; held until done0.
- sel0  input  1  requester 0 opcode: 0 = add (a+b), 1 = subtract (a-b).
- a0  input  WIDTH  requester 0 operand a.
- b0  input  WIDTH  requester 0 operand b.
- req1, sel1, a1, b1  input  1/1/WIDTH/WIDTH  requester 1, same meaning.
- gnt0  output  1  requester 0 owns the adder (EXEC and DONE).
- gnt1  output  1  requester 1 owns the adder.
- done0  output  1  one-cycle pulse; result/c_out valid for requester 0.
- done1  output  1  one-cycle pulse for requester 1.
- result  output  WIDTH  registered adder sum of the last completed operation.
- c_out  output  1  registered adder carry of the last completed operation.
- busy  output  1  high whenever state != IDLE.
- add_a  output  WIDTH  shared adder operand a (latched copy).
- add_b  output  WIDTH  shared adder operand b (latched copy).
- add_sel  output  1  shared adder SEL (latched opcode).
- add_sum  input  WIDTH  shared adder Data_Out.
- add_cout  input  1  shared adder c_out.

Behaviour:
- Reset values: state = IDLE; gnt0, gnt1, done0, done1, busy = 0; result = 0; c_out = 0; add_a = 0; add_b = 0; add_sel = 0; last_grant = 1, so requester 0 wins first.
- The FSM has three states: IDLE, EXEC and DONE.
- IDLE:
  - Sample req0/req1 at the clock edge.
  - If both are low, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the requester that is not last_grant (round-robin).
  - On grant: latch that requester's a, b and sel into add_a/add_b/add_sel, set its gnt, set last_grant, and go to EXEC.
- EXEC:
  - The adder settles combinationally from the latched operands.
  - At the end of the cycle, capture add_sum into result and add_cout into c_out, then go to DONE.
- DONE:
  - Pulse the granted requester's done for exactly one cycle; gnt stays high.
  - Next edge: clear gnt and done, return to IDLE.
- Latency: a request sampled in IDLE at edge N produces done high during cycle N+2. Back-to-back throughput is one operation per 3 cycles.
- A requester must drop req in its done cycle, or it re-requests at the next IDLE sample.
- Operands and opcode are latched at grant. Input changes during EXEC/DONE have no effect.
- If the granted req drops mid-operation, the operation still completes and done still pulses.
- result and c_out hold their value until the next EXEC capture.
- Subtract is two's complement inside the adder: c_out = 1 means no borrow.
- Widths are WIDTH bits with no extension; the carry appears only on c_out.
- reset asserted in any state returns to IDLE within one edge. A pending done is not issued, and result/c_out clear to 0.
- At most one gnt and at most one done are high at any time.

Optional Feature:
- Macro: ADDER_ARB_OVERFLOW_EN.
- When defined: adds output ovf (1 bit, reset 0), captured with result in EXEC.
  - ovf = signed overflow.
  - For add: ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - For subtract: ovf = (a[MSB]!=b[MSB]) && (sum[MSB]!=a[MSB]).
- When undefined: no ovf port and no related logic. All other behaviour is identical.

Decomposition:
- Shared package adder_arb_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_DONE=2'd2;
  - the opcode constants OP_ADD=1'b0, OP_SUB=1'b1.
- One natural sub-module, rr_arb2: the 2-way round-robin grant logic. Inputs are req0, req1, last_grant; outputs are a one-hot grant.
- FSM, operand latch and result registers stay in adder_arbiter.

Test Plan:
- Single add: reset, then req0 with a0=8'h11, b0=8'h11, sel0=0. Expect gnt0 next cycle, done0 two cycles after the sampled edge, result=8'h22, c_out=0.
- Subtract: req1 with a1=8'h55, b1=8'h2A, sel1=1. Expect done1, result=8'h2B, c_out=1. With ADDER_ARB_OVERFLOW_EN, ovf=0.
- Wrap-around: req0 with a0=8'hFF, b0=8'h01, add. Expect result=8'h00, c_out=1, ovf=0.
- Signed overflow: 8'h7F+8'h01. Expect result=8'h80, c_out=0, ovf=1.
- Contention:
  - After reset, req0 and req1 are high in the same cycle and held. Expect a grant order of 0, 1, 0, 1.
  - Expect exactly one done pulse per 3 cycles and gnt0 never equal to gnt1.
  - Change a0 during EXEC. Expect no effect on result.
- Reset mid-op: assert reset during EXEC. Expect no done pulse, state IDLE, result=0, c_out=0, busy=0. The next req0 is served normally.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the two-requester adder arbiter.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Two's-complement overflow from operand/sum sign bits; subtract flips b's sign test.
    function automatic logic signed_ovf(input logic sel, input logic a_msb,
                                        input logic b_msb, input logic s_msb);
        logic same_sign;
        same_sign = (sel == OP_SUB) ? (a_msb != b_msb) : (a_msb == b_msb);
        return same_sign && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last time wins.
module rr_arb2
    import adder_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant selection
    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder/subtractor between two requesters (IDLE -> EXEC -> DONE).
// Optional signed-overflow output enabled by macro ADDER_ARB_OVERFLOW_EN.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             sel0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic             sel1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             busy,
`ifdef ADDER_ARB_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sel,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    state_t           state_q;
    logic             gnt0_q, gnt1_q, done0_q, done1_q, busy_q, c_out_q;
    logic             add_sel_q, last_grant_q;
    logic [WIDTH-1:0] result_q, add_a_q, add_b_q;
    logic [1:0]       grant_s;
`ifdef ADDER_ARB_OVERFLOW_EN
    logic             ovf_q;
`endif

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .grant      (grant_s)
    );

    // Sequencer FSM with operand latch and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            busy_q       <= 1'b0;
            result_q     <= {WIDTH{1'b0}};
            c_out_q      <= 1'b0;
            add_a_q      <= {WIDTH{1'b0}};
            add_b_q      <= {WIDTH{1'b0}};
            add_sel_q    <= OP_ADD;
            last_grant_q <= 1'b1;
`ifdef ADDER_ARB_OVERFLOW_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_s == 2'b01) begin
                        add_a_q      <= a0;
                        add_b_q      <= b0;
                        add_sel_q    <= sel0;
                        gnt0_q       <= 1'b1;
                        last_grant_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_EXEC;
                    end else if (grant_s == 2'b10) begin
                        add_a_q      <= a1;
                        add_b_q      <= b1;
                        add_sel_q    <= sel1;
                        gnt1_q       <= 1'b1;
                        last_grant_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_EXEC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    result_q <= add_sum;
                    c_out_q  <= add_cout;
`ifdef ADDER_ARB_OVERFLOW_EN
                    ovf_q    <= signed_ovf(add_sel_q, add_a_q[WIDTH-1],
                                           add_b_q[WIDTH-1], add_sum[WIDTH-1]);
`endif
                    done0_q  <= gnt0_q;
                    done1_q  <= gnt1_q;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign busy    = busy_q;
    assign result  = result_q;
    assign c_out   = c_out_q;
    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_sel = add_sel_q;
`ifdef ADDER_ARB_OVERFLOW_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter; models the external shared adder.
module tb_adder_arbiter;

    localparam int WIDTH = 8;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0 = 1'b0, sel0 = 1'b0, req1 = 1'b0, sel1 = 1'b0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             gnt0, gnt1, done0, done1, c_out, busy, add_sel, add_cout;
    logic [WIDTH-1:0] result, add_a, add_b, add_sum;
    logic             ovf_obs;

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // External adder: SEL=1 computes a + ~b + 1
    assign {add_cout, add_sum} = add_sel ? ({1'b0, add_a} + {1'b0, ~add_b} + 9'd1)
                                         : ({1'b0, add_a} + {1'b0, add_b});

    adder_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .sel0(sel0), .a0(a0), .b0(b0),
        .req1(req1), .sel1(sel1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .c_out(c_out), .busy(busy),
`ifdef ADDER_ARB_OVERFLOW_EN
        .ovf(ovf_obs),
`endif
        .add_a(add_a), .add_b(add_b), .add_sel(add_sel),
        .add_sum(add_sum), .add_cout(add_cout)
    );
`ifndef ADDER_ARB_OVERFLOW_EN
    assign ovf_obs = 1'b0;
`endif

    // Mutual exclusion of grants and done pulses
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if ((gnt0 & gnt1) !== 1'b0) begin
                bad++;
                $display("FAIL gnt_excl: gnt0=%b gnt1=%b required not both", gnt0, gnt1);
            end
            total++;
            if ((done0 & done1) !== 1'b0) begin
                bad++;
                $display("FAIL done_excl: done0=%b done1=%b required not both", done0, done1);
            end
        end
    end

    task automatic pop_check(input string name, input logic id);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s_sb: done seen with empty scoreboard", name);
            return;
        end
        e = sb.pop_front();
        if (id !== e.id || result !== e.res || c_out !== e.cout) begin
            bad++;
            $display("FAIL %s: id=%b result=%h c_out=%b required id=%b result=%h c_out=%b",
                     name, id, result, c_out, e.id, e.res, e.cout);
        end
`ifdef ADDER_ARB_OVERFLOW_EN
        total++;
        if (ovf_obs !== e.ovf) begin
            bad++;
            $display("FAIL %s_ovf: ovf=%b required %b", name, ovf_obs, e.ovf);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({gnt0, gnt1, done0, done1, busy, c_out, add_sel} !== 7'd0 ||
            result !== 8'h00 || add_a !== 8'h00 || add_b !== 8'h00 || ovf_obs !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: g=%b%b d=%b%b busy=%b res=%h c=%b a=%h b=%h required all zero",
                     gnt0, gnt1, done0, done1, busy, result, c_out, add_a, add_b);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One isolated request with exact latency checks
    task automatic test_single(input string name, input logic id, input logic sel,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] er, input logic ec, input logic eo);
        if (id) begin req1 = 1'b1; sel1 = sel; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; sel0 = sel; a0 = a; b0 = b; end
        sb.push_back('{id: id, res: er, cout: ec, ovf: eo});
        @(negedge clk);
        total++;
        if ({gnt1, gnt0} !== (id ? 2'b10 : 2'b01) || busy !== 1'b1 || {done1, done0} !== 2'b00) begin
            bad++;
            $display("FAIL %s_exec: gnt=%b%b busy=%b done=%b%b required gnt for %0d busy=1 done=00",
                     name, gnt1, gnt0, busy, done1, done0, id);
        end
        @(negedge clk);
        total++;
        if ({done1, done0} !== (id ? 2'b10 : 2'b01) || {gnt1, gnt0} !== (id ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL %s_done: done=%b%b gnt=%b%b required requester %0d", name, done1, done0,
                     gnt1, gnt0, id);
        end else begin
            pop_check(name, id);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        total++;
        if ({gnt1, gnt0, done1, done0, busy} !== 5'd0) begin
            bad++;
            $display("FAIL %s_idle: g=%b%b d=%b%b busy=%b required zero", name, gnt1, gnt0,
                     done1, done0, busy);
        end
    endtask

    task automatic test_contention();
        logic exp_id;
        req0 = 1'b1; sel0 = 1'b0; a0 = 8'h10; b0 = 8'h20;
        req1 = 1'b1; sel1 = 1'b1; a1 = 8'h09; b1 = 8'h03;
        sb.push_back('{id: 1'b0, res: 8'h30, cout: 1'b0, ovf: 1'b0});
        sb.push_back('{id: 1'b1, res: 8'h06, cout: 1'b1, ovf: 1'b0});
        sb.push_back('{id: 1'b0, res: 8'h60, cout: 1'b0, ovf: 1'b0});
        sb.push_back('{id: 1'b1, res: 8'h06, cout: 1'b1, ovf: 1'b0});
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            exp_id = ((i - 1) / 3) % 2;
            if (i == 1) a0 = 8'h40;
            total++;
            if ((i % 3 == 0) ? ({gnt1, gnt0} !== 2'b00)
                             : ({gnt1, gnt0} !== (exp_id ? 2'b10 : 2'b01))) begin
                bad++;
                $display("FAIL contention_gnt[%0d]: gnt=%b%b required owner %0d", i, gnt1, gnt0,
                         (i % 3 == 0) ? -1 : int'(exp_id));
            end
            total++;
            if ((done0 | done1) !== (i % 3 == 2)) begin
                bad++;
                $display("FAIL contention_done[%0d]: done=%b%b required pulse=%0d", i, done1,
                         done0, (i % 3 == 2));
            end else if (i % 3 == 2) begin
                pop_check("contention", done1);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL contention_drain: left=%0d busy=%b required 0 0", sb.size(), busy);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_op();
        req0 = 1'b1; sel0 = 1'b0; a0 = 8'h33; b0 = 8'h44;
        @(negedge clk);
        total++;
        if (gnt0 !== 1'b1) begin
            bad++;
            $display("FAIL midrst_gnt: gnt0=%b required 1", gnt0);
        end
        reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        total++;
        if ({gnt0, gnt1, done0, done1, busy, c_out} !== 6'd0 || result !== 8'h00) begin
            bad++;
            $display("FAIL midrst_state: g=%b%b d=%b%b busy=%b res=%h c=%b required zero",
                     gnt0, gnt1, done0, done1, busy, result, c_out);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({done0, done1, busy} !== 3'd0) begin
            bad++;
            $display("FAIL midrst_nodone: d=%b%b busy=%b required zero", done0, done1, busy);
        end
        test_single("after_reset", 1'b0, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single("add", 1'b0, 1'b0, 8'h11, 8'h11, 8'h22, 1'b0, 1'b0);
        test_single("sub", 1'b1, 1'b1, 8'h55, 8'h2A, 8'h2B, 1'b1, 1'b0);
        test_single("wrap", 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        test_single("sovf", 1'b1, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        test_single("sub_borrow", 1'b0, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        test_reset();
        test_contention();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
